// File: rtl/bist_pkg.sv
// Shared types and the MISR next-state function for the logic-BIST response path.
package bist_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COMPACT = 1'b1
    } state_t;

    // Widest signature the step function handles; callers zero-extend into it.
    localparam int MISR_MAX_W = 64;

    localparam logic [3:0] DEF_POLY = 4'b1000;
    localparam logic [3:0] DEF_SEED = 4'b1101;

    // One MISR step on the low w bits. Stage 0 always takes the MSB feedback;
    // stage i>=1 shifts from i-1 and takes the MSB only where poly[i] is set.
    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] q,
        input logic [MISR_MAX_W-1:0] d,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    w
    );
        logic                  msb;
        logic [MISR_MAX_W-1:0] res;
        msb = 1'b0;
        res = '0;
        for (int i = 0; i < MISR_MAX_W; i++) begin
            if (i == w - 1) msb = q[i];
        end
        res[0] = d[0] ^ msb;
        for (int i = 1; i < MISR_MAX_W; i++) begin
            if (i < w) res[i] = d[i] ^ q[i-1] ^ (poly[i] & msb);
        end
        return res;
    endfunction

endpackage

// File: rtl/misr_reg.sv
// WIDTH-bit MISR register: seed load takes priority over a compaction step.
module misr_reg
    import bist_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] nxt,
    output logic [WIDTH-1:0] q
);

    // Next value is exported so the final beat can be captured as the signature
    // in the same edge that reseeds the register.
    always_comb begin
        nxt = WIDTH'(misr_step(MISR_MAX_W'(q), MISR_MAX_W'(d), MISR_MAX_W'(POLY), WIDTH));
    end

    // Register update: reseed wins over step, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= SEED;
        else if (load) q <= SEED;
        else if (step) q <= nxt;
    end

endmodule

// File: rtl/misr_compactor.sv
// Windowed MISR compactor: counts accepted beats, closes the window on the
// final beat, latches the signature and a sticky pass/fail against golden.
module misr_compactor
    import bist_pkg::*;
#(
    parameter int               WIDTH  = 4,
    parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEF_SEED),
    parameter int               WINDOW = 7,
    parameter int               CW     = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cont,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic [CW-1:0]    beat_cnt,
    output logic             done,
    output logic [WIDTH-1:0] signature,
    output logic             pass,
    output logic             fail
);

    state_t           state, state_nxt;
    logic             final_beat;
    logic             step;
    logic             load;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] q;

    // Beat qualification: start overrides any beat in the same cycle, so a
    // coincident final beat is dropped and the window aborts instead.
    always_comb begin
        final_beat = 1'b0;
        step       = 1'b0;
        if (state == COMPACT && in_valid && !start) begin
            if (beat_cnt == CW'(WINDOW - 1)) final_beat = 1'b1;
            else                             step       = 1'b1;
        end
        load = start | final_beat;
    end

    misr_reg #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_reg (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .step (step),
        .d    (in_data),
        .nxt  (nxt),
        .q    (q)
    );

    // Next-state: start always (re)opens a window; the final beat either
    // chains into a new window (cont) or returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = COMPACT;
            end
            COMPACT: begin
                if (start)           state_nxt = COMPACT;
                else if (final_beat) state_nxt = cont ? COMPACT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == COMPACT);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Beat counter: cleared on any window open or close, bumped on mid-window beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       beat_cnt <= '0;
        else if (load) beat_cnt <= '0;
        else if (step) beat_cnt <= beat_cnt + CW'(1);
    end

    // Completion: one-cycle done, held signature and sticky verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            signature <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
        end else begin
            done <= final_beat;
            if (final_beat) begin
                signature <= nxt;
                pass      <= (nxt == golden);
                fail      <= (nxt != golden);
            end
        end
    end

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor: default 4-bit, WINDOW=1 and 8-bit instances.
module tb_misr_compactor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- default instance: WIDTH=4, POLY=1000, SEED=1101, WINDOW=7
    logic       start = 0, cont = 0, in_valid = 0;
    logic [3:0] in_data = 0, golden = 0;
    logic       busy, done, pass, fail;
    logic [2:0] beat_cnt;
    logic [3:0] signature;

    misr_compactor u_dut (
        .clk(clk), .rst(rst), .start(start), .cont(cont), .in_valid(in_valid),
        .in_data(in_data), .golden(golden), .busy(busy), .beat_cnt(beat_cnt),
        .done(done), .signature(signature), .pass(pass), .fail(fail)
    );

    // ---- WINDOW=1 instance
    logic       s1_start = 0, s1_cont = 0, s1_valid = 0;
    logic [3:0] s1_data = 0, s1_golden = 0;
    logic       s1_busy, s1_done, s1_pass, s1_fail;
    logic [0:0] s1_cnt;
    logic [3:0] s1_sig;

    misr_compactor #(.WINDOW(1)) u_w1 (
        .clk(clk), .rst(rst), .start(s1_start), .cont(s1_cont), .in_valid(s1_valid),
        .in_data(s1_data), .golden(s1_golden), .busy(s1_busy), .beat_cnt(s1_cnt),
        .done(s1_done), .signature(s1_sig), .pass(s1_pass), .fail(s1_fail)
    );

    // ---- 8-bit instance
    logic       s8_start = 0, s8_cont = 0, s8_valid = 0;
    logic [7:0] s8_data = 0, s8_golden = 0;
    logic       s8_busy, s8_done, s8_pass, s8_fail;
    logic [2:0] s8_cnt;
    logic [7:0] s8_sig;

    misr_compactor #(.WIDTH(8), .POLY(8'h1D), .SEED(8'hFF), .WINDOW(7)) u_w8 (
        .clk(clk), .rst(rst), .start(s8_start), .cont(s8_cont), .in_valid(s8_valid),
        .in_data(s8_data), .golden(s8_golden), .busy(s8_busy), .beat_cnt(s8_cnt),
        .done(s8_done), .signature(s8_sig), .pass(s8_pass), .fail(s8_fail)
    );

    // Shift-left-with-feedback form of the 8-bit MISR, POLY=8'h1D.
    function automatic logic [7:0] m8(input logic [7:0] q, input logic [7:0] d);
        logic m;
        m = q[7];
        return {q[6:0], m} ^ (m ? 8'h1C : 8'h00) ^ d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [3:0] seq [7] = '{4'h3, 4'h6, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    initial begin
        logic [7:0] mq, mn;
        do_reset();

        // reset values
        chk("rst_busy", busy, 0);
        chk("rst_cnt", beat_cnt, 0);
        chk("rst_done", done, 0);
        chk("rst_sig", signature, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_q", u_dut.u_reg.q, 4'hD);

        // default window, 7 zero beats, golden 1000
        start = 1; tick(); start = 0;
        chk("t1_busy", busy, 1);
        chk("t1_cnt0", beat_cnt, 0);
        golden = 4'h8;
        for (int b = 0; b < 7; b++) begin
            in_valid = 1; in_data = 0;
            tick();
            if (b < 6) begin
                chk("t1_q", u_dut.u_reg.q, seq[b]);
                chk("t1_cnt", beat_cnt, b + 1);
                chk("t1_nodone", done, 0);
            end
        end
        in_valid = 0;
        chk("t1_done", done, 1);
        chk("t1_sig", signature, 4'h8);
        chk("t1_pass", pass, 1);
        chk("t1_fail", fail, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_reseed", u_dut.u_reg.q, 4'hD);
        tick();
        chk("t1_done_1cyc", done, 0);
        chk("t1_pass_sticky", pass, 1);

        // WINDOW=1: one beat 1111 vs golden 0000
        s1_start = 1; tick(); s1_start = 0;
        s1_valid = 1; s1_data = 4'hF; s1_golden = 4'h0;
        tick();
        s1_valid = 0;
        chk("w1_done", s1_done, 1);
        chk("w1_sig", s1_sig, 4'hC);
        chk("w1_fail", s1_fail, 1);
        chk("w1_pass", s1_pass, 0);
        chk("w1_busy", s1_busy, 0);
        chk("w1_cnt", s1_cnt, 0);

        // abort by start, then gapped window
        do_reset();
        start = 1; tick(); start = 0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1; in_data = 0; tick();
        end
        in_valid = 0;
        chk("t3_cnt3", beat_cnt, 3);
        start = 1; tick(); start = 0;
        chk("t3_cnt_restart", beat_cnt, 0);
        chk("t3_busy", busy, 1);
        chk("t3_q_reseed", u_dut.u_reg.q, 4'hD);
        golden = 4'h8;
        for (int b = 1; b <= 7; b++) begin
            in_valid = 1; in_data = 0; tick();
            in_valid = 0;
            chk("t3_done_beat", done, (b == 7));
            tick();
            chk("t3_done_gap", done, 0);
            chk("t3_cnt_gap", beat_cnt, (b == 7) ? 0 : b);
        end
        chk("t3_sig", signature, 4'h8);
        chk("t3_pass", pass, 1);

        // start coincident with final beat aborts; start with a beat drops it
        start = 1; tick(); start = 0;
        for (int b = 0; b < 6; b++) begin
            in_valid = 1; in_data = 4'h5; tick();
        end
        start = 1; in_valid = 1; golden = 4'h0; tick();
        start = 0; in_valid = 0;
        chk("t3b_cnt", beat_cnt, 0);
        chk("t3b_busy", busy, 1);
        tick();
        chk("t3b_nodone", done, 0);
        chk("t3b_sig_held", signature, 4'h8);
        chk("t3b_pass_held", pass, 1);
        chk("t3b_fail_held", fail, 0);

        // continuous mode, 14 back-to-back zero beats
        do_reset();
        cont = 1; golden = 4'h8;
        start = 1; tick(); start = 0;
        for (int b = 1; b <= 14; b++) begin
            in_valid = 1; in_data = 0; tick();
            chk("t4_busy", busy, 1);
            chk("t4_done", done, (b == 7 || b == 14));
            if (b == 7 || b == 14) chk("t4_sig", signature, 4'h8);
        end
        in_valid = 0; cont = 0;
        tick();
        chk("t4_done_off", done, 0);
        chk("t4_pass", pass, 1);

        // reset mid-window
        do_reset();
        start = 1; tick(); start = 0;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1; in_data = 4'h3; tick();
        end
        in_valid = 0;
        rst = 1; #1;
        chk("t5_async_busy", busy, 0);
        chk("t5_async_cnt", beat_cnt, 0);
        tick();
        rst = 0;
        tick();
        chk("t5_done", done, 0);
        chk("t5_busy", busy, 0);
        chk("t5_sig", signature, 0);
        chk("t5_pass", pass, 0);
        chk("t5_fail", fail, 0);
        chk("t5_q", u_dut.u_reg.q, 4'hD);
        for (int b = 0; b < 3; b++) begin
            in_valid = 1; in_data = 4'hA; tick();
            in_valid = 0; tick();
        end
        chk("t5_idle_cnt", beat_cnt, 0);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_done", done, 0);

        // 8-bit, 100 continuous windows of random beats
        s8_cont = 1;
        s8_start = 1; tick(); s8_start = 0;
        mq = 8'hFF;
        for (int w = 0; w < 100; w++) begin
            for (int b = 0; b < 7; b++) begin
                s8_data = 8'($urandom);
                mn = m8(mq, s8_data);
                if (b == 6) s8_golden = ($urandom_range(0, 1) == 1) ? mn : 8'($urandom);
                s8_valid = 1;
                tick();
                if (b == 6) begin
                    chk("w8_done", s8_done, 1);
                    chk("w8_sig", s8_sig, mn);
                    chk("w8_pass", s8_pass, (s8_golden == mn));
                    chk("w8_fail", s8_fail, (s8_golden != mn));
                    mq = 8'hFF;
                end else begin
                    mq = mn;
                end
            end
        end
        s8_valid = 0;
        tick();
        chk("w8_done_off", s8_done, 0);
        chk("w8_busy", s8_busy, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
